// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU control path: opcode values,
// ALU operation encodings, sequencer state encoding and decode classes.
package cpu_pkg;

   localparam int unsigned OP_NOP = 0;
   localparam int unsigned OP_LDA = 1;
   localparam int unsigned OP_STA = 2;
   localparam int unsigned OP_ADD = 3;
   localparam int unsigned OP_SUB = 4;
   localparam int unsigned OP_JMP = 5;
   localparam int unsigned OP_JZ  = 6;
   localparam int unsigned OP_HLT = 7;

   localparam logic [1:0] ALU_PASS = 2'b00;
   localparam logic [1:0] ALU_ADD  = 2'b01;
   localparam logic [1:0] ALU_SUB  = 2'b10;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_FETCH   = 3'd1;
   localparam logic [2:0] S_DECODE  = 3'd2;
   localparam logic [2:0] S_EXEC_RD = 3'd3;
   localparam logic [2:0] S_EXEC_WR = 3'd4;
   localparam logic [2:0] S_HALT    = 3'd5;

   // What DECODE does next for a given opcode.
   typedef enum logic [2:0] {
      CLS_NEXT,
      CLS_READ,
      CLS_WRITE,
      CLS_JMP,
      CLS_JZ,
      CLS_HALT
   } op_class_t;

endpackage

// File: rtl/opcode_decode.sv
// Combinational opcode decoder: maps an opcode to its next-state class,
// the ALU operation used on the accumulator load and an illegal flag.
module opcode_decode
   import cpu_pkg::*;
#(
   parameter int OPC_W = 4
) (
   input  logic [OPC_W-1:0] opcode,
   output op_class_t        op_class,
   output logic [1:0]       alu_op,
   output logic             illegal
);

   logic [31:0] op_ext;

   assign op_ext = 32'(opcode);

   always_comb begin
      op_class = CLS_NEXT;
      alu_op   = ALU_PASS;
      illegal  = 1'b0;
      case (op_ext)
         OP_NOP: op_class = CLS_NEXT;
         OP_LDA: op_class = CLS_READ;
         OP_STA: op_class = CLS_WRITE;
         OP_ADD: begin
            op_class = CLS_READ;
            alu_op   = ALU_ADD;
         end
         OP_SUB: begin
            op_class = CLS_READ;
            alu_op   = ALU_SUB;
         end
         OP_JMP: op_class = CLS_JMP;
         OP_JZ:  op_class = CLS_JZ;
         OP_HLT: op_class = CLS_HALT;
         // Undefined opcodes behave as NOP but are flagged.
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer for a simple accumulator CPU: fetch/decode/execute
// control FSM with Moore/Mealy outputs decoded from state and inputs.
module instr_sequencer
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int OPC_W  = 4
) (
   input  logic             clk,
   input  logic             REST,
   input  logic [OPC_W-1:0] OPCODE,
   input  logic             ACC_ZERO,
   input  logic             MEM_ACK,
   input  logic             RESUME,
   output logic             MEM_RD,
   output logic             MEM_WR,
   output logic             ADDR_SEL,
   output logic             IR_LOAD,
   output logic             PC_EN,
   output logic             PC_LOAD,
   output logic             AC_LOAD,
   output logic [1:0]       ALU_OP,
   output logic             HALTED,
   output logic             ILLEGAL
);

   // The address mux only chooses between PC and IR operand, so the
   // address width never reaches this block; reject a degenerate setting.
   if (ADDR_W < 1) begin : g_bad_addr_w
      logic [-1:0] addr_w_must_be_positive;
   end

   logic [2:0]       state;
   logic [2:0]       nxt;
   logic [OPC_W-1:0] op_q;
   logic [OPC_W-1:0] dec_in;
   op_class_t        dec_class;
   logic [1:0]       dec_alu;
   logic             dec_illegal;

   logic             rd, wr, asel, irl, pce, pcl, acl, hlt, ill;
   logic [1:0]       aop;

   // DECODE looks at the live IR opcode; EXEC_RD uses the copy latched there.
   assign dec_in = (state == S_DECODE) ? OPCODE : op_q;

   opcode_decode #(.OPC_W(OPC_W)) u_decode (
      .opcode   (dec_in),
      .op_class (dec_class),
      .alu_op   (dec_alu),
      .illegal  (dec_illegal)
   );

   always_ff @(posedge clk or posedge REST) begin
      if (REST) begin
         state <= S_IDLE;
         op_q  <= '0;
      end else begin
         state <= nxt;
         if (state == S_DECODE) op_q <= OPCODE;
      end
   end

   // Memory handshake: MEM_RD or MEM_WR (with ADDR_SEL) is a request that
   // stays unchanged until an edge where MEM_ACK is 1; that edge completes it.
   always_comb begin
      nxt  = state;
      rd   = 1'b0;
      wr   = 1'b0;
      asel = 1'b0;
      irl  = 1'b0;
      pce  = 1'b0;
      pcl  = 1'b0;
      acl  = 1'b0;
      aop  = ALU_PASS;
      hlt  = 1'b0;
      ill  = 1'b0;
      case (state)
         S_IDLE: nxt = S_FETCH;
         S_FETCH: begin
            rd = 1'b1;
            if (MEM_ACK) begin
               irl = 1'b1;
               pce = 1'b1;
               nxt = S_DECODE;
            end
         end
         S_DECODE: begin
            ill = dec_illegal;
            case (dec_class)
               CLS_READ:  nxt = S_EXEC_RD;
               CLS_WRITE: nxt = S_EXEC_WR;
               CLS_HALT:  nxt = S_HALT;
               CLS_JMP: begin
                  pcl = 1'b1;
                  nxt = S_FETCH;
               end
               CLS_JZ: begin
                  pcl = ACC_ZERO;
                  nxt = S_FETCH;
               end
               default: nxt = S_FETCH;
            endcase
         end
         S_EXEC_RD: begin
            rd   = 1'b1;
            asel = 1'b1;
            if (MEM_ACK) begin
               acl = 1'b1;
               aop = dec_alu;
               nxt = S_FETCH;
            end
         end
         S_EXEC_WR: begin
            wr   = 1'b1;
            asel = 1'b1;
            if (MEM_ACK) nxt = S_FETCH;
         end
         S_HALT: begin
            hlt = 1'b1;
            if (RESUME) nxt = S_FETCH;
         end
         default: nxt = S_IDLE;
      endcase
   end

   // Outputs are forced low for the whole time reset is held.
   assign MEM_RD   = rd   & ~REST;
   assign MEM_WR   = wr   & ~REST;
   assign ADDR_SEL = asel & ~REST;
   assign IR_LOAD  = irl  & ~REST;
   assign PC_EN    = pce  & ~REST;
   assign PC_LOAD  = pcl  & ~REST;
   assign AC_LOAD  = acl  & ~REST;
   assign ALU_OP   = aop  & {2{~REST}};
   assign HALTED   = hlt  & ~REST;
   assign ILLEGAL  = ill  & ~REST;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed testbench for instr_sequencer: per-cycle input vectors with
// hand-computed expected output words, checked in each scenario task.
module tb_instr_sequencer;

   // Expected output word bit masks:
   // {MEM_RD, MEM_WR, ADDR_SEL, IR_LOAD, PC_EN, PC_LOAD, AC_LOAD, ALU_OP[1:0], HALTED, ILLEGAL}
   localparam logic [10:0] O_NONE = 11'h000;
   localparam logic [10:0] O_RD   = 11'h400;
   localparam logic [10:0] O_WR   = 11'h200;
   localparam logic [10:0] O_AS   = 11'h100;
   localparam logic [10:0] O_IR   = 11'h080;
   localparam logic [10:0] O_PCE  = 11'h040;
   localparam logic [10:0] O_PCL  = 11'h020;
   localparam logic [10:0] O_ACL  = 11'h010;
   localparam logic [10:0] O_SUB  = 11'h008;
   localparam logic [10:0] O_ADD  = 11'h004;
   localparam logic [10:0] O_HLT  = 11'h002;
   localparam logic [10:0] O_ILL  = 11'h001;
   localparam logic [10:0] O_FACK = O_RD | O_IR | O_PCE;

   logic       clk;
   logic       REST;
   logic [3:0] OPCODE;
   logic       ACC_ZERO;
   logic       MEM_ACK;
   logic       RESUME;
   logic       MEM_RD, MEM_WR, ADDR_SEL, IR_LOAD, PC_EN, PC_LOAD, AC_LOAD;
   logic [1:0] ALU_OP;
   logic       HALTED, ILLEGAL;
   logic [10:0] outs;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0]  op;
      logic        az;
      logic        ack;
      logic        res;
   } vin_t;

   vin_t        in_q[$];
   logic [10:0] exp_q[$];

   instr_sequencer #(.ADDR_W(12), .OPC_W(4)) dut (
      .clk      (clk),
      .REST     (REST),
      .OPCODE   (OPCODE),
      .ACC_ZERO (ACC_ZERO),
      .MEM_ACK  (MEM_ACK),
      .RESUME   (RESUME),
      .MEM_RD   (MEM_RD),
      .MEM_WR   (MEM_WR),
      .ADDR_SEL (ADDR_SEL),
      .IR_LOAD  (IR_LOAD),
      .PC_EN    (PC_EN),
      .PC_LOAD  (PC_LOAD),
      .AC_LOAD  (AC_LOAD),
      .ALU_OP   (ALU_OP),
      .HALTED   (HALTED),
      .ILLEGAL  (ILLEGAL)
   );

   assign outs = {MEM_RD, MEM_WR, ADDR_SEL, IR_LOAD, PC_EN, PC_LOAD, AC_LOAD,
                  ALU_OP, HALTED, ILLEGAL};

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Exclusive request / exclusive PC update, sampled mid-cycle.
   always @(negedge clk) begin
      if (!REST) begin
         checks++;
         if ((MEM_RD && MEM_WR) || (PC_EN && PC_LOAD)) begin
            errors++;
            $display("FAIL exclusive_outputs at %0t: got outs=%h, required RD/WR and PC_EN/PC_LOAD not both set",
                     $time, outs);
         end
      end
   end

   // Driver: queue one cycle of inputs and its expected output word.
   task automatic add(input logic [3:0] op, input logic az, input logic ack,
                      input logic res, input logic [10:0] exp);
      vin_t v;
      v.op = op; v.az = az; v.ack = ack; v.res = res;
      in_q.push_back(v);
      exp_q.push_back(exp);
   endtask

   // Driver: apply one queued input set just after the edge, let it settle.
   task automatic drive(input vin_t v);
      OPCODE   = v.op;
      ACC_ZERO = v.az;
      MEM_ACK  = v.ack;
      RESUME   = v.res;
      #1;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      REST = 1'b1; OPCODE = 4'd0; ACC_ZERO = 1'b0; MEM_ACK = 1'b1; RESUME = 1'b1;
      #2;
      checks++;
      if (outs !== O_NONE) begin
         errors++; $display("FAIL reset_async: got %h required %h", outs, O_NONE);
      end
      repeat (2) next_cycle();
      checks++;
      if (outs !== O_NONE) begin
         errors++; $display("FAIL reset_held: got %h required %h", outs, O_NONE);
      end
      MEM_ACK = 1'b0; RESUME = 1'b0;
      REST = 1'b0;
   endtask

   task automatic test_zero_wait_nop();
      add(4'd0, 1'b0, 1'b1, 1'b0, O_NONE);   // IDLE ignores ACK
      add(4'd0, 1'b0, 1'b1, 1'b0, O_FACK);   // FETCH zero-wait
      add(4'd0, 1'b0, 1'b1, 1'b0, O_NONE);   // DECODE NOP, ACK ignored
      add(4'd0, 1'b0, 1'b0, 1'b0, O_RD);     // FETCH at cycle 3
      while (in_q.size() > 0) begin
         drive(in_q.pop_front());
         checks++;
         if (outs !== exp_q[0]) begin
            errors++; $display("FAIL zero_wait_nop: got %h required %h", outs, exp_q[0]);
         end
         void'(exp_q.pop_front());
         next_cycle();
      end
   endtask

   task automatic test_exec_rd();
      add(4'd3, 1'b0, 1'b1, 1'b0, O_FACK);
      add(4'd3, 1'b0, 1'b0, 1'b0, O_NONE);
      add(4'd0, 1'b0, 1'b0, 1'b0, O_RD | O_AS);           // opcode changed: latched copy used
      add(4'd0, 1'b0, 1'b0, 1'b0, O_RD | O_AS);
      add(4'd0, 1'b0, 1'b1, 1'b0, O_RD | O_AS | O_ACL | O_ADD);
      add(4'd4, 1'b0, 1'b1, 1'b0, O_FACK);
      add(4'd4, 1'b0, 1'b1, 1'b0, O_NONE);
      add(4'd7, 1'b0, 1'b1, 1'b0, O_RD | O_AS | O_ACL | O_SUB);
      add(4'd1, 1'b0, 1'b1, 1'b0, O_FACK);
      add(4'd1, 1'b0, 1'b0, 1'b0, O_NONE);
      add(4'd1, 1'b0, 1'b1, 1'b0, O_RD | O_AS | O_ACL);   // LDA: pass
      add(4'd1, 1'b0, 1'b0, 1'b0, O_RD);
      while (in_q.size() > 0) begin
         drive(in_q.pop_front());
         checks++;
         if (outs !== exp_q[0]) begin
            errors++; $display("FAIL exec_rd: got %h required %h", outs, exp_q[0]);
         end
         void'(exp_q.pop_front());
         next_cycle();
      end
   endtask

   task automatic test_jumps();
      add(4'd6, 1'b1, 1'b1, 1'b0, O_FACK);
      add(4'd6, 1'b1, 1'b0, 1'b0, O_PCL);                 // JZ taken
      add(4'd6, 1'b0, 1'b1, 1'b0, O_FACK);
      add(4'd6, 1'b0, 1'b0, 1'b0, O_NONE);                // JZ not taken
      add(4'd5, 1'b0, 1'b1, 1'b0, O_FACK);
      add(4'd5, 1'b0, 1'b0, 1'b0, O_PCL);                 // JMP
      add(4'd0, 1'b0, 1'b0, 1'b0, O_RD);
      while (in_q.size() > 0) begin
         drive(in_q.pop_front());
         checks++;
         if (outs !== exp_q[0]) begin
            errors++; $display("FAIL jumps: got %h required %h", outs, exp_q[0]);
         end
         void'(exp_q.pop_front());
         next_cycle();
      end
   endtask

   task automatic test_store();
      add(4'd2, 1'b0, 1'b1, 1'b0, O_FACK);
      add(4'd2, 1'b0, 1'b0, 1'b0, O_NONE);
      add(4'd0, 1'b0, 1'b0, 1'b0, O_WR | O_AS);
      add(4'd0, 1'b0, 1'b1, 1'b0, O_WR | O_AS);
      add(4'd0, 1'b0, 1'b0, 1'b0, O_RD);
      while (in_q.size() > 0) begin
         drive(in_q.pop_front());
         checks++;
         if (outs !== exp_q[0]) begin
            errors++; $display("FAIL store: got %h required %h", outs, exp_q[0]);
         end
         void'(exp_q.pop_front());
         next_cycle();
      end
   endtask

   task automatic test_halt();
      add(4'd7, 1'b0, 1'b0, 1'b1, O_RD);                  // RESUME in FETCH ignored
      add(4'd7, 1'b0, 1'b1, 1'b0, O_FACK);
      add(4'd7, 1'b0, 1'b0, 1'b0, O_NONE);
      for (int i = 0; i < 10; i++) add(4'd7, 1'b0, 1'(i % 2), 1'b0, O_HLT);
      add(4'd7, 1'b0, 1'b1, 1'b1, O_HLT);
      add(4'd0, 1'b0, 1'b0, 1'b0, O_RD);
      while (in_q.size() > 0) begin
         drive(in_q.pop_front());
         checks++;
         if (outs !== exp_q[0]) begin
            errors++; $display("FAIL halt: got %h required %h", outs, exp_q[0]);
         end
         void'(exp_q.pop_front());
         next_cycle();
      end
   endtask

   task automatic test_illegal();
      add(4'd9, 1'b0, 1'b1, 1'b0, O_FACK);
      add(4'd9, 1'b0, 1'b1, 1'b0, O_ILL);
      add(4'd15, 1'b0, 1'b1, 1'b0, O_FACK);
      add(4'd15, 1'b0, 1'b0, 1'b0, O_ILL);
      add(4'd0, 1'b0, 1'b0, 1'b0, O_RD);
      while (in_q.size() > 0) begin
         drive(in_q.pop_front());
         checks++;
         if (outs !== exp_q[0]) begin
            errors++; $display("FAIL illegal: got %h required %h", outs, exp_q[0]);
         end
         void'(exp_q.pop_front());
         next_cycle();
      end
   endtask

   task automatic test_reset_mid_write();
      add(4'd2, 1'b0, 1'b1, 1'b0, O_FACK);
      add(4'd2, 1'b0, 1'b0, 1'b0, O_NONE);
      add(4'd2, 1'b0, 1'b0, 1'b0, O_WR | O_AS);
      while (in_q.size() > 0) begin
         drive(in_q.pop_front());
         checks++;
         if (outs !== exp_q[0]) begin
            errors++; $display("FAIL reset_mid_write setup: got %h required %h", outs, exp_q[0]);
         end
         void'(exp_q.pop_front());
         next_cycle();
      end
      MEM_ACK = 1'b0;
      #1;
      REST = 1'b1;
      #1;
      checks++;
      if (outs !== O_NONE) begin
         errors++; $display("FAIL reset_mid_write immediate: got %h required %h", outs, O_NONE);
      end
      MEM_ACK = 1'b1;
      next_cycle();
      REST = 1'b0;
      add(4'd0, 1'b0, 1'b1, 1'b0, O_NONE);   // IDLE after release
      add(4'd0, 1'b0, 1'b0, 1'b0, O_RD);     // then FETCH
      while (in_q.size() > 0) begin
         drive(in_q.pop_front());
         checks++;
         if (outs !== exp_q[0]) begin
            errors++; $display("FAIL reset_mid_write release: got %h required %h", outs, exp_q[0]);
         end
         void'(exp_q.pop_front());
         next_cycle();
      end
   endtask

   initial begin
      test_reset();
      test_zero_wait_nop();
      test_exec_rd();
      test_jumps();
      test_store();
      test_halt();
      test_illegal();
      test_reset_mid_write();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL expose parameter ADDR_W, default 12, width of the memory address and of the PC.
REQ-002 SHALL expose parameter OPC_W, default 4, width of the opcode field of the instruction register.
REQ-003 SHALL provide port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL provide port REST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL provide port OPCODE  input  OPC_W  opcode field of the registered IR; valid the cycle after IR_LOAD.
REQ-006 SHALL provide port ACC_ZERO  input  1  accumulator equals zero.
REQ-007 SHALL provide port MEM_ACK  input  1  memory completed the current read or write at this edge.
REQ-008 SHALL provide port RESUME  input  1  restart from HALT.
REQ-009 SHALL provide port MEM_RD  output  1  memory read request.
REQ-010 SHALL provide port MEM_WR  output  1  memory write request.
REQ-011 SHALL provide port ADDR_SEL  output  1  address mux: 0 = PC, 1 = IR operand.
REQ-012 SHALL provide port IR_LOAD  output  1  load the fetched word into the IR.
REQ-013 SHALL provide port PC_EN  output  1  increment the PC.
REQ-014 SHALL provide port PC_LOAD  output  1  load the PC from the IR operand.
REQ-015 SHALL provide port AC_LOAD  output  1  load the accumulator from the ALU.
REQ-016 SHALL provide port ALU_OP  output  2  ALU operation: 00 = pass, 01 = add, 10 = sub.
REQ-017 SHALL provide port HALTED  output  1  high while in HALT.
REQ-018 SHALL provide port ILLEGAL  output  1  one-cycle pulse on an undefined opcode.

Function
REQ-019 SHALL implement the states IDLE, FETCH, DECODE, EXEC_RD, EXEC_WR and HALT, with outputs decoded combinationally from state and inputs.
REQ-020 IDLE SHALL drive all outputs 0 and SHALL go to FETCH unconditionally on the next edge.
REQ-021 FETCH SHALL drive MEM_RD=1 and ADDR_SEL=0 until an edge with MEM_ACK=1.
REQ-022 In the FETCH cycle where MEM_ACK=1, FETCH SHALL also drive IR_LOAD=1 and PC_EN=1 and then go to DECODE; zero-wait (ACK in the first cycle) SHALL be supported.
REQ-023 DECODE SHALL last exactly one cycle and SHALL act on OPCODE as follows.
  - 0 NOP: go to FETCH.
  - 1 LDA, 3 ADD, 4 SUB: go to EXEC_RD.
  - 2 STA: go to EXEC_WR.
  - 5 JMP: PC_LOAD=1, go to FETCH.
  - 6 JZ: PC_LOAD=ACC_ZERO, go to FETCH.
  - 7 HLT: go to HALT.
  - 8..15: ILLEGAL=1, treat as NOP.
REQ-024 EXEC_RD SHALL drive MEM_RD=1 and ADDR_SEL=1.
REQ-025 On the EXEC_RD ACK cycle, EXEC_RD SHALL drive AC_LOAD=1 with ALU_OP 00 for LDA, 01 for ADD or 10 for SUB, then go to FETCH.
REQ-026 EXEC_RD SHALL latch the opcode internally at DECODE.
REQ-027 EXEC_WR SHALL drive MEM_WR=1 and ADDR_SEL=1 until ACK, then go to FETCH.
REQ-028 HALT SHALL drive HALTED=1 and all other outputs 0, and SHALL go to FETCH on an edge with RESUME=1.
REQ-029 RESUME outside HALT SHALL be ignored.
REQ-030 MEM_ACK SHALL be ignored in IDLE, DECODE and HALT.
REQ-031 MEM_RD and MEM_WR SHALL never both be 1.
REQ-032 PC_EN and PC_LOAD SHALL never both be 1.
REQ-033 A request SHALL be held stable, with the same ADDR_SEL, until ACK.
REQ-034 Minimum latency per instruction SHALL be: NOP/JMP/JZ 2 cycles; LDA/ADD/SUB/STA 3 cycles; plus memory wait cycles.

Reset
REQ-035 REST=1 SHALL force state to IDLE asynchronously and clear the latched opcode.
REQ-036 All outputs SHALL be 0 while REST=1, including reset asserted mid-request; no partial IR_LOAD, AC_LOAD or PC update SHALL occur.
REQ-037 The first FETCH SHALL occur at the second rising edge after REST deasserts, so the PC has cleared first.

Structure
REQ-038 Shared package cpu_pkg SHALL hold the opcode constants, the ALU_OP encodings and the state encoding.
REQ-039 One sub-module, opcode_decode, SHALL be used: combinational, mapping opcode to next-state class, ALU_OP and ILLEGAL.

Verification
REQ-040 Reset then zero-wait memory: IDLE, FETCH(MEM_RD=1, ACK, IR_LOAD=1, PC_EN=1), DECODE with OPCODE=0 -> back in FETCH at cycle 3.
REQ-041 ADD with 2 wait cycles in EXEC_RD: MEM_RD held 3 cycles with ADDR_SEL=1; AC_LOAD=1 and ALU_OP=01 only in the ACK cycle.
REQ-042 JZ with ACC_ZERO=1 -> PC_LOAD=1, PC_EN=0 in DECODE; JZ with ACC_ZERO=0 -> PC_LOAD=0.
REQ-043 HLT -> HALTED=1 held 10 cycles despite MEM_ACK toggling; RESUME=1 -> FETCH next cycle; RESUME in FETCH ignored.
REQ-044 OPCODE=9 -> single ILLEGAL pulse, no memory access, FETCH next.
REQ-045 REST asserted mid-EXEC_WR with MEM_WR=1 -> MEM_WR=0 immediately; after release IDLE, then FETCH.
